bitrev_reorder: RTL and testbench

BITREV_REORDER -- requirements
Module: bitrev_reorder

---
 rtl/bitrev_reorder.sv | 76 +++++++
 tb/tb_bitrev_reorder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/bitrev_reorder.sv
// rtl/bitrev_reorder.sv - bit-reversed to natural order FFT output reorder
// Ping-pong buffer: one bank fills in arrival order while the other drains in bit-reversed address order.
module bitrev_reorder #(
  parameter int LGSIZE = 12,
  parameter int WIDTH  = 36
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clk_enable,
  input  logic             i_sync,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sync
);

  localparam int N = 1 << LGSIZE;

  logic [WIDTH-1:0]  r_mem [0:2*N-1];
  logic              r_wait_for_sync;
  logic [LGSIZE-1:0] r_wr_cnt;
  logic              r_wr_bank;
  logic              r_seen_wrap;
  logic [WIDTH-1:0]  r_data;
  logic              r_sync;

  logic [LGSIZE-1:0] w_rd_idx;
  logic              w_wr_en;
  logic              w_frame_ready;

  always_comb begin
    w_rd_idx = '0;
    for (int i = 0; i < LGSIZE; i++) begin
      w_rd_idx[i] = r_wr_cnt[LGSIZE-1-i];
    end
  end

  // The sync sample itself is accepted while unlocked, so it lands at {0,0}.
  assign w_wr_en       = i_clk_enable && (!r_wait_for_sync || i_sync);
  assign w_frame_ready = !r_wait_for_sync && (r_wr_bank || r_seen_wrap);

  always_ff @(posedge i_clk) begin
    if (!i_reset && w_wr_en) begin
      r_mem[{r_wr_bank, r_wr_cnt}] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wait_for_sync <= 1'b1;
      r_wr_cnt        <= '0;
      r_wr_bank       <= 1'b0;
      r_seen_wrap     <= 1'b0;
    end else if (w_wr_en) begin
      r_wait_for_sync          <= 1'b0;
      {r_wr_bank, r_wr_cnt}    <= {r_wr_bank, r_wr_cnt} + (LGSIZE+1)'(1);
      if (r_wr_bank && (&r_wr_cnt)) begin
        r_seen_wrap <= 1'b1;
      end
    end
  end

  // Read bank is always the one not being written, so no read/write collision.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data <= '0;
      r_sync <= 1'b0;
    end else if (i_clk_enable) begin
      r_sync <= w_frame_ready && (r_wr_cnt == '0);
      r_data <= w_frame_ready ? r_mem[{~r_wr_bank, w_rd_idx}] : '0;
    end
  end

  assign o_data = r_data;
  assign o_sync = r_sync;

endmodule

// File: tb/tb_bitrev_reorder.sv
// tb/tb_bitrev_reorder.sv - scoreboard bench for bitrev_reorder
// Reference model keeps the accepted input stream and predicts each output from frame/index arithmetic.
module tb_bitrev_reorder;

  localparam int LG = 4;
  localparam int N  = 16;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         sy;
  logic [W-1:0] din;
  logic [W-1:0] o_data;
  logic         o_sync;

  bitrev_reorder #(.LGSIZE(LG), .WIDTH(W)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_clk_enable (en),
    .i_sync       (sy),
    .i_data       (din),
    .o_data       (o_data),
    .o_sync       (o_sync)
  );

  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W:0]   sb_q [$];
  logic [W-1:0] hist [0:1023];
  bit           m_locked = 0;
  int           m_t = 0;
  logic [W-1:0] last_d = '0;
  logic         last_s = 1'b0;

  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < LG; i++) if (v[i]) r |= 1 << (LG-1-i);
    return r;
  endfunction

  task automatic step(input logic r, input logic e, input logic s, input logic [W-1:0] d);
    logic [W-1:0] ed;
    logic         es;
    logic [W:0]   got;
    rst = r; en = e; sy = s; din = d;
    if (r) begin
      ed = '0; es = 1'b0;
      m_locked = 0; m_t = 0;
    end else if (e) begin
      ed = '0; es = 1'b0;
      if (m_locked && m_t >= N) begin
        ed = hist[(m_t/N - 1)*N + brev(m_t % N)];
        es = ((m_t % N) == 0);
      end
      if (!m_locked && s) begin
        m_locked = 1; m_t = 0;
      end
      if (m_locked) begin
        hist[m_t] = d;
        m_t++;
      end
    end else begin
      ed = last_d; es = last_s;
    end
    last_d = ed; last_s = es;
    sb_q.push_back({es, ed});
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    n_vec++;
    assert (o_data === got[W-1:0]) else begin
      n_err++;
      $error("FAIL o_data observed=%h expected=%h at t=%0t", o_data, got[W-1:0], $time);
    end
    n_vec++;
    assert (o_sync === got[W]) else begin
      n_err++;
      $error("FAIL o_sync observed=%b expected=%b at t=%0t", o_sync, got[W], $time);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sy = 1'b0; din = '0;
    // Reset state, enable low and high
    step(1, 0, 0, 8'h00);
    step(1, 1, 0, 8'h00);

    // Pre-sync junk, then one bit-reversed frame and a flush frame
    for (int k = 0; k < 5; k++) step(0, 1, 0, 8'hAA);
    for (int k = 0; k < N; k++) step(0, 1, k == 0, 8'(brev(k)));
    for (int k = 0; k < N + 2; k++) step(0, 1, 0, 8'h00);

    // Three back-to-back raw frames
    step(1, 1, 0, 8'h00);
    for (int k = 0; k < 3*N; k++) step(0, 1, k == 0, 8'(k));
    for (int k = 0; k < N + 2; k++) step(0, 1, 0, 8'h00);

    // 50% clock enable
    step(1, 1, 0, 8'h00);
    for (int k = 0; k < N; k++) begin
      step(0, 1, k == 0, 8'(brev(k)));
      step(0, 0, 0, 8'h5A);
    end
    for (int k = 0; k < N + 2; k++) begin
      step(0, 1, 0, 8'h00);
      step(0, 0, 1, 8'hC3);
    end

    // Reset at sample 7 of frame 2, then relock
    step(1, 1, 0, 8'h00);
    for (int k = 0; k < N + 7; k++) step(0, 1, k == 0, 8'(k + 8'h40));
    step(1, 1, 0, 8'h00);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 8'h77);
    for (int k = 0; k < 2*N + 3; k++) step(0, 1, k == 0, 8'(k + 8'h80));

    // Stray sync at sample 5 of frame 2
    step(1, 1, 0, 8'h00);
    for (int k = 0; k < 3*N; k++) step(0, 1, (k == 0) || (k == N + 5), 8'(k + 8'hB0));
    for (int k = 0; k < N + 2; k++) step(0, 1, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
